// File: rtl/data_memory_mmio.sv
// Data memory for the CPU load/store stage: byte/halfword RAM, LED and digit registers,
// and a ROM data window with wait states, behind a req/ready/rvalid handshake.
module data_memory_mmio #(
    parameter logic [15:0] RAM_BASE   = 16'h1000,
    parameter int          RAM_BYTES  = 256,
    parameter logic [15:0] LED_BASE   = 16'h2000,
    parameter int          LED_NUM    = 4,
    parameter logic [15:0] DIGIT_BASE = 16'h3000,
    parameter int          DIGIT_NUM  = 6,
    parameter int          ROM_LAT    = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   req,
    input  logic                   wmem,
    input  logic                   memc,
    input  logic [15:0]            DAddress,
    input  logic [15:0]            DataIn,
    output logic                   ready,
    output logic                   rvalid,
    output logic [15:0]            DataOut,
    output logic                   fault,
    output logic                   rom_req,
    output logic [15:0]            ROMDataAddress,
    input  logic [15:0]            DataFromROM,
    output logic [LED_NUM-1:0]     leds,
    output logic [8*DIGIT_NUM-1:0] digits
);

    localparam int          RAM_AW    = $clog2(RAM_BYTES);
    localparam logic [16:0] RAM_END   = {1'b0, RAM_BASE} + 17'(RAM_BYTES);
    localparam logic [16:0] LED_END   = {1'b0, LED_BASE} + 17'(LED_NUM);
    localparam logic [16:0] DIGIT_END = {1'b0, DIGIT_BASE} + 17'(DIGIT_NUM);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_ROM_WAIT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   ready_s;
    logic [7:0]             cnt_r;
    logic                   rom_byte_r;
    logic                   rvalid_r;
    logic                   fault_r;
    logic                   rom_req_r;
    logic [15:0]            data_out_r;
    logic [15:0]            rom_addr_r;
    logic [LED_NUM-1:0]     leds_r;
    logic [8*DIGIT_NUM-1:0] digits_r;
    logic [7:0]             mem_r [RAM_BYTES];

    logic [16:0]            addr_ext_s;
    logic                   is_rom_s;
    logic                   is_ram_s;
    logic                   is_led_s;
    logic                   is_dig_s;
    logic                   fault_s;
    logic                   accept_s;
    logic                   rom_rd_s;
    logic [RAM_AW-1:0]      ram_lo_s;
    logic [RAM_AW-1:0]      ram_hi_s;
    logic [3:0]             led_idx_s;
    logic [2:0]             dig_idx_s;
    logic [LED_NUM-1:0]     led_sel_s;
    logic [DIGIT_NUM-1:0]   dig_sel_s;
    logic                   led_rd_s;
    logic [7:0]             dig_rd_s;
    logic [15:0]            rd_data_s;

    assign addr_ext_s = {1'b0, DAddress};
    assign is_rom_s   = (DAddress < RAM_BASE);
    assign is_ram_s   = (DAddress >= RAM_BASE) && (addr_ext_s < RAM_END);
    assign is_led_s   = (DAddress >= LED_BASE) && (addr_ext_s < LED_END);
    assign is_dig_s   = (DAddress >= DIGIT_BASE) && (addr_ext_s < DIGIT_END);

    // Misaligned halfwords, halfwords to byte-only registers, ROM writes and holes all fault.
    assign fault_s  = (memc && DAddress[0]) ||
                      (memc && (is_led_s || is_dig_s)) ||
                      (wmem && is_rom_s) ||
                      !(is_rom_s || is_ram_s || is_led_s || is_dig_s);
    assign accept_s = req && ready_s;
    assign rom_rd_s = is_rom_s && !wmem && !fault_s;

    assign ram_lo_s  = RAM_AW'(DAddress - RAM_BASE);
    assign ram_hi_s  = {ram_lo_s[RAM_AW-1:1], 1'b1};
    assign led_idx_s = 4'(DAddress - LED_BASE);
    assign dig_idx_s = 3'(DAddress - DIGIT_BASE);

    // One-hot selects for the LED and digit register banks.
    always_comb begin
        for (int i = 0; i < LED_NUM; i++) begin
            led_sel_s[i] = (led_idx_s == 4'(i));
        end
        for (int i = 0; i < DIGIT_NUM; i++) begin
            dig_sel_s[i] = (dig_idx_s == 3'(i));
        end
    end

    // Read-data mux for the single-cycle regions.
    always_comb begin
        led_rd_s = |(leds_r & led_sel_s);
        dig_rd_s = 8'h00;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            dig_rd_s = dig_rd_s | (digits_r[8*i +: 8] & {8{dig_sel_s[i]}});
        end
        if (is_ram_s) begin
            rd_data_s = memc ? {mem_r[ram_hi_s], mem_r[ram_lo_s]} : {8'h00, mem_r[ram_lo_s]};
        end else if (is_led_s) begin
            rd_data_s = {15'h0000, led_rd_s};
        end else if (is_dig_s) begin
            rd_data_s = {8'h00, dig_rd_s};
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: a ROM wait ends on the edge the counter runs out.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && rom_rd_s) begin
                    state_next_s = ST_ROM_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ROM_WAIT: begin
                if (cnt_r == 8'd1) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ROM_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:     ready_s = 1'b1;
            ST_ROM_WAIT: ready_s = 1'b0;
            default:     ready_s = 1'b0;
        endcase
    end

    // Response, MMIO register and ROM wait-counter datapath.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rvalid_r   <= 1'b0;
            fault_r    <= 1'b0;
            rom_req_r  <= 1'b0;
            data_out_r <= 16'h0000;
            rom_addr_r <= 16'h0000;
            cnt_r      <= 8'd0;
            rom_byte_r <= 1'b0;
            leds_r     <= '0;
            digits_r   <= '0;
        end else begin
            rvalid_r  <= 1'b0;
            fault_r   <= 1'b0;
            rom_req_r <= 1'b0;
            if (accept_s) begin
                if (fault_s) begin
                    fault_r <= 1'b1;
                    if (!wmem) begin
                        data_out_r <= 16'h0000;
                        rvalid_r   <= 1'b1;
                    end
                end else if (wmem) begin
                    for (int i = 0; i < LED_NUM; i++) begin
                        if (is_led_s && led_sel_s[i]) leds_r[i] <= DataIn[0];
                    end
                    for (int i = 0; i < DIGIT_NUM; i++) begin
                        if (is_dig_s && dig_sel_s[i]) digits_r[8*i +: 8] <= DataIn[7:0];
                    end
                end else if (is_rom_s) begin
                    rom_req_r  <= 1'b1;
                    rom_addr_r <= DAddress;
                    cnt_r      <= 8'(ROM_LAT);
                    rom_byte_r <= !memc;
                end else begin
                    data_out_r <= rd_data_s;
                    rvalid_r   <= 1'b1;
                end
            end else if (state_r == ST_ROM_WAIT) begin
                cnt_r <= cnt_r - 8'd1;
                if (cnt_r == 8'd1) begin
                    data_out_r <= rom_byte_r ? {8'h00, DataFromROM[7:0]} : DataFromROM;
                    rvalid_r   <= 1'b1;
                end
            end
        end
    end

    // RAM array: not reset, written on the acceptance edge.
    always_ff @(posedge CLK) begin
        if (RESET && accept_s && wmem && is_ram_s && !fault_s) begin
            mem_r[ram_lo_s] <= DataIn[7:0];
            if (memc) mem_r[ram_hi_s] <= DataIn[15:8];
        end
    end

    assign ready          = ready_s;
    assign rvalid         = rvalid_r;
    assign DataOut        = data_out_r;
    assign fault          = fault_r;
    assign rom_req        = rom_req_r;
    assign ROMDataAddress = rom_addr_r;
    assign leds           = leds_r;
    assign digits         = digits_r;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio: directed scenarios plus randomized accesses
// checked against an address-map reference model.
module tb_data_memory_mmio;

    localparam int ROM_LAT = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        req = 1'b0;
    logic        wmem = 1'b0;
    logic        memc = 1'b0;
    logic [15:0] DAddress = 16'h0000;
    logic [15:0] DataIn = 16'h0000;
    logic [15:0] DataFromROM = 16'h0000;
    logic        ready, rvalid, fault, rom_req;
    logic [15:0] DataOut, ROMDataAddress;
    logic [3:0]  leds;
    logic [47:0] digits;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] ram_m [0:255];
    logic [3:0] leds_m;
    logic [7:0] dig_m [0:5];

    bit          o_acc, o_rvalid, o_fault, o_early, o_romreq;
    int          o_stall, o_wait;
    logic [15:0] o_data, o_romaddr;

    data_memory_mmio #(
        .RAM_BASE(16'h1000), .RAM_BYTES(256), .LED_BASE(16'h2000), .LED_NUM(4),
        .DIGIT_BASE(16'h3000), .DIGIT_NUM(6), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .wmem(wmem), .memc(memc),
        .DAddress(DAddress), .DataIn(DataIn), .ready(ready), .rvalid(rvalid),
        .DataOut(DataOut), .fault(fault), .rom_req(rom_req),
        .ROMDataAddress(ROMDataAddress), .DataFromROM(DataFromROM),
        .leds(leds), .digits(digits)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] rom_val(input logic [15:0] a);
        logic [15:0] p;
        if (a == 16'h0010) return 16'hA5C3;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    // Synchronous ROM: data appears one cycle after the strobe, so it is valid at the capture edge.
    always @(posedge CLK) begin
        if (rom_req) DataFromROM <= rom_val(ROMDataAddress);
    end

    // 0 ROM, 1 RAM, 2 LED, 3 DIGIT, 4 unmapped
    function automatic int region(input logic [15:0] a);
        int v;
        v = int'(a);
        if (v < 'h1000) return 0;
        if (v < 'h1100) return 1;
        if (v >= 'h2000 && v < 'h2004) return 2;
        if (v >= 'h3000 && v < 'h3006) return 3;
        return 4;
    endfunction

    function automatic logic [47:0] digits_model();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[8*i +: 8] = dig_m[i];
        return v;
    endfunction

    task automatic model_step(input bit w, input bit hw, input logic [15:0] a, input logic [15:0] d,
                              output bit e_fault, output logic [15:0] e_data, output bit e_rom);
        int r;
        int o;
        logic [15:0] rv;
        r = region(a);
        e_fault = (hw && a[0]) || (hw && (r == 2 || r == 3)) || (w && r == 0) || (r == 4);
        e_data = 16'h0000;
        e_rom = 1'b0;
        o = (r == 1) ? int'(a) - 'h1000 : (r == 2) ? int'(a) - 'h2000 : (r == 3) ? int'(a) - 'h3000 : 0;
        if (!e_fault) begin
            if (w) begin
                if (r == 1) begin
                    ram_m[o] = d[7:0];
                    if (hw) ram_m[o+1] = d[15:8];
                end
                if (r == 2) leds_m[o] = d[0];
                if (r == 3) dig_m[o] = d[7:0];
            end else begin
                rv = rom_val(a);
                if (r == 0) begin
                    e_rom = 1'b1;
                    e_data = hw ? rv : {8'h00, rv[7:0]};
                end
                if (r == 1) e_data = hw ? {ram_m[o+1], ram_m[o]} : {8'h00, ram_m[o]};
                if (r == 2) e_data = {15'h0000, leds_m[o]};
                if (r == 3) e_data = {8'h00, dig_m[o]};
            end
        end
    endtask

    // Drives one request starting at a falling edge and records the DUT response.
    task automatic access(input bit w, input bit hw, input logic [15:0] a, input logic [15:0] d);
        req = 1'b1; wmem = w; memc = hw; DAddress = a; DataIn = d;
        o_stall = 0;
        while (!ready && o_stall < 50) begin @(negedge CLK); o_stall++; end
        o_acc = ready;
        @(negedge CLK);
        o_fault = fault; o_romreq = rom_req; o_romaddr = ROMDataAddress;
        o_early = 1'b0; o_wait = 0;
        while (!ready && o_wait < 50) begin
            o_early = o_early | rvalid;
            o_wait++;
            @(negedge CLK);
        end
        o_rvalid = rvalid; o_data = DataOut;
    endtask

    task automatic idle_cycle();
        req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        compared++; if (leds !== 4'h0) begin mismatched++; $display("FAIL reset_leds got %h expected 0", leds); end
        compared++; if (digits !== 48'h0) begin mismatched++; $display("FAIL reset_digits got %h expected 0", digits); end
        compared++; if ({ready, rvalid, fault, rom_req} !== 4'b1000) begin mismatched++; $display("FAIL reset_flags got %b expected 1000", {ready, rvalid, fault, rom_req}); end
        compared++; if ({DataOut, ROMDataAddress} !== 32'h0) begin mismatched++; $display("FAIL reset_data got %h expected 0", {DataOut, ROMDataAddress}); end
        RESET = 1'b1;
        leds_m = 4'h0;
        for (int i = 0; i < 6; i++) dig_m[i] = 8'h00;
        @(negedge CLK);
        compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready got %b expected 1", ready); end
    endtask

    task automatic test_fill();
        bit ef, er;
        logic [15:0] ed, d;
        for (int o = 0; o < 256; o += 2) begin
            d = 16'($urandom);
            model_step(1'b1, 1'b1, 16'(32'h1000 + o), d, ef, ed, er);
            access(1'b1, 1'b1, 16'(32'h1000 + o), d);
            compared++; if ({o_fault, o_rvalid} !== 2'b00) begin mismatched++; $display("FAIL fill_write got fault/rvalid %b expected 00", {o_fault, o_rvalid}); end
        end
        idle_cycle();
    endtask

    task automatic test_retain();
        bit ef, er;
        logic [15:0] ed, v;
        v = 16'($urandom);
        model_step(1'b1, 1'b1, 16'h1000, v, ef, ed, er);
        access(1'b1, 1'b1, 16'h1000, v);
        idle_cycle();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        access(1'b0, 1'b1, 16'h1000, 16'h0000);
        compared++; if ({o_rvalid, o_data} !== {1'b1, v}) begin mismatched++; $display("FAIL retain_read got %b/%h expected 1/%h", o_rvalid, o_data, v); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        bit ef, er;
        logic [15:0] ed;
        model_step(1'b1, 1'b1, 16'h1004, 16'hBEEF, ef, ed, er);
        access(1'b1, 1'b1, 16'h1004, 16'hBEEF);
        compared++; if ({o_rvalid, o_fault} !== 2'b00) begin mismatched++; $display("FAIL b2b_write got %b expected 00", {o_rvalid, o_fault}); end
        access(1'b0, 1'b0, 16'h1005, 16'h0000);
        compared++; if ({o_rvalid, o_data} !== {1'b1, 16'h00BE}) begin mismatched++; $display("FAIL b2b_byte_read got %b/%h expected 1/00be", o_rvalid, o_data); end
        access(1'b0, 1'b1, 16'h1004, 16'h0000);
        compared++; if ({o_rvalid, o_data} !== {1'b1, 16'hBEEF}) begin mismatched++; $display("FAIL b2b_half_read got %b/%h expected 1/beef", o_rvalid, o_data); end
        compared++; if (o_stall !== 0) begin mismatched++; $display("FAIL b2b_bubble got %0d stall cycles expected 0", o_stall); end
        idle_cycle();
    endtask

    task automatic test_misaligned();
        bit ef, er;
        logic [15:0] ed, k1, k2;
        k1 = 16'($urandom); k2 = 16'($urandom);
        model_step(1'b1, 1'b1, 16'h1002, k1, ef, ed, er); access(1'b1, 1'b1, 16'h1002, k1);
        model_step(1'b1, 1'b1, 16'h1004, k2, ef, ed, er); access(1'b1, 1'b1, 16'h1004, k2);
        model_step(1'b1, 1'b1, 16'h1003, 16'h1234, ef, ed, er);
        access(1'b1, 1'b1, 16'h1003, 16'h1234);
        compared++; if ({o_fault, o_rvalid} !== 2'b10) begin mismatched++; $display("FAIL misaligned_fault got %b expected 10", {o_fault, o_rvalid}); end
        access(1'b0, 1'b1, 16'h1002, 16'h0000);
        compared++; if (o_data !== k1) begin mismatched++; $display("FAIL misaligned_low got %h expected %h", o_data, k1); end
        compared++; if (o_fault !== 1'b0) begin mismatched++; $display("FAIL fault_pulse_width got %b expected 0", o_fault); end
        access(1'b0, 1'b1, 16'h1004, 16'h0000);
        compared++; if (o_data !== k2) begin mismatched++; $display("FAIL misaligned_high got %h expected %h", o_data, k2); end
        access(1'b0, 1'b1, 16'h1003, 16'h0000);
        compared++; if ({o_fault, o_rvalid, o_data} !== {2'b11, 16'h0000}) begin mismatched++; $display("FAIL misaligned_read got %b/%h expected 11/0000", {o_fault, o_rvalid}, o_data); end
        idle_cycle();
    endtask

    task automatic test_rom();
        logic [15:0] rv;
        access(1'b0, 1'b1, 16'h0010, 16'h0000);
        compared++; if ({o_romreq, o_romaddr} !== {1'b1, 16'h0010}) begin mismatched++; $display("FAIL rom_strobe got %b/%h expected 1/0010", o_romreq, o_romaddr); end
        compared++; if (o_wait !== ROM_LAT) begin mismatched++; $display("FAIL rom_ready_low got %0d expected %0d", o_wait, ROM_LAT); end
        compared++; if ({o_early, o_rvalid, o_data} !== {2'b01, 16'hA5C3}) begin mismatched++; $display("FAIL rom_data got %b/%h expected 01/a5c3", {o_early, o_rvalid}, o_data); end
        rv = rom_val(16'h0033);
        access(1'b0, 1'b0, 16'h0033, 16'h0000);
        compared++; if (o_data !== {8'h00, rv[7:0]}) begin mismatched++; $display("FAIL rom_byte got %h expected %h", o_data, {8'h00, rv[7:0]}); end
        access(1'b1, 1'b0, 16'h0040, 16'h00FF);
        compared++; if ({o_fault, o_romreq, o_rvalid} !== 3'b100 || o_wait !== 0) begin mismatched++; $display("FAIL rom_write got %b wait %0d expected 100 wait 0", {o_fault, o_romreq, o_rvalid}, o_wait); end
        idle_cycle();
    endtask

    task automatic test_mmio();
        bit ef, er;
        logic [15:0] ed;
        logic [3:0]  snap;
        model_step(1'b1, 1'b0, 16'h2003, 16'h0001, ef, ed, er); access(1'b1, 1'b0, 16'h2003, 16'h0001);
        model_step(1'b1, 1'b0, 16'h3002, 16'h005A, ef, ed, er); access(1'b1, 1'b0, 16'h3002, 16'h005A);
        access(1'b0, 1'b0, 16'h2003, 16'h0000);
        compared++; if ({o_rvalid, o_data} !== {1'b1, 16'h0001}) begin mismatched++; $display("FAIL led_read got %b/%h expected 1/0001", o_rvalid, o_data); end
        compared++; if (leds[3] !== 1'b1) begin mismatched++; $display("FAIL led3 got %b expected 1", leds[3]); end
        compared++; if (digits[23:16] !== 8'h5A) begin mismatched++; $display("FAIL digit2 got %h expected 5a", digits[23:16]); end
        snap = leds;
        access(1'b1, 1'b1, 16'h2000, 16'hFFFF);
        compared++; if (o_fault !== 1'b1) begin mismatched++; $display("FAIL led_half_fault got %b expected 1", o_fault); end
        compared++; if (leds !== snap) begin mismatched++; $display("FAIL led_half_nochange got %h expected %h", leds, snap); end
        model_step(1'b1, 1'b0, 16'h2003, 16'hFFFE, ef, ed, er); access(1'b1, 1'b0, 16'h2003, 16'hFFFE);
        compared++; if (leds[3] !== 1'b0) begin mismatched++; $display("FAIL led_bit0_only got %b expected 0", leds[3]); end
        access(1'b0, 1'b0, 16'h3002, 16'h0000);
        compared++; if (o_data !== 16'h005A) begin mismatched++; $display("FAIL digit_read got %h expected 005a", o_data); end
        idle_cycle();
    endtask

    task automatic test_reset_mid_rom();
        bit seen, ef, er;
        logic [15:0] ed;
        seen = 1'b0;
        req = 1'b1; wmem = 1'b0; memc = 1'b1; DAddress = 16'h0020; DataIn = 16'h0000;
        @(negedge CLK);
        compared++; if ({ready, rom_req} !== 2'b01) begin mismatched++; $display("FAIL midrom_wait got %b expected 01", {ready, rom_req}); end
        req = 1'b0;
        RESET = 1'b0;
        repeat (4) begin @(negedge CLK); seen = seen | rvalid; end
        RESET = 1'b1;
        leds_m = 4'h0;
        for (int i = 0; i < 6; i++) dig_m[i] = 8'h00;
        repeat (3) begin @(negedge CLK); seen = seen | rvalid; end
        compared++; if ({seen, ready} !== 2'b01) begin mismatched++; $display("FAIL midrom_abort got %b expected 01", {seen, ready}); end
        model_step(1'b1, 1'b0, 16'h2001, 16'h0001, ef, ed, er); access(1'b1, 1'b0, 16'h2001, 16'h0001);
        access(1'b1, 1'b1, 16'h4000, 16'hFFFF);
        compared++; if ({o_fault, o_rvalid} !== 2'b10) begin mismatched++; $display("FAIL unmapped_fault got %b expected 10", {o_fault, o_rvalid}); end
        compared++; if ({leds, digits} !== {leds_m, digits_model()}) begin mismatched++; $display("FAIL unmapped_nochange got %h/%h expected %h/%h", leds, digits, leds_m, digits_model()); end
        idle_cycle();
    endtask

    task automatic test_random();
        bit w, hw, ef, er;
        logic [15:0] a, d, ed;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom); hw = 1'($urandom); d = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 16'($urandom_range(0, 'h0FFF));
                1, 2:    a = 16'('h1000 + $urandom_range(0, 255));
                3:       a = 16'('h2000 + $urandom_range(0, 4));
                4:       a = 16'('h3000 + $urandom_range(0, 6));
                default: begin
                    case ($urandom_range(0, 5))
                        0: a = 16'h0FFF; 1: a = 16'h10FE; 2: a = 16'h1100;
                        3: a = 16'h1FFF; 4: a = 16'h4000; default: a = 16'hFFFF;
                    endcase
                end
            endcase
            if (hw && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            model_step(w, hw, a, d, ef, ed, er);
            access(w, hw, a, d);
            compared++; if ({o_acc, o_fault, o_rvalid, o_romreq} !== {1'b1, ef, !w, er}) begin mismatched++; $display("FAIL rand_flags a=%h w=%b hw=%b got %b expected %b", a, w, hw, {o_acc, o_fault, o_rvalid, o_romreq}, {1'b1, ef, !w, er}); end
            compared++; if (o_wait !== (er ? ROM_LAT : 0) || o_early !== 1'b0) begin mismatched++; $display("FAIL rand_wait a=%h got %0d/%b expected %0d/0", a, o_wait, o_early, er ? ROM_LAT : 0); end
            if (!w) begin
                compared++; if (o_data !== ed) begin mismatched++; $display("FAIL rand_data a=%h hw=%b got %h expected %h", a, hw, o_data, ed); end
            end
            if (er) begin
                compared++; if (o_romaddr !== a) begin mismatched++; $display("FAIL rand_romaddr got %h expected %h", o_romaddr, a); end
            end
            compared++; if ({leds, digits} !== {leds_m, digits_model()}) begin mismatched++; $display("FAIL rand_regs got %h/%h expected %h/%h", leds, digits, leds_m, digits_model()); end
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_retain();
        test_back_to_back();
        test_misaligned();
        test_rom();
        test_mmio();
        test_reset_mid_rom();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
